// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: valid/ready handshake bundle for the immediate-extension stage.
// The master drives in_* and out_ready. The slave (the stage) drives in_ready and the out_* results.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_sel, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_sel, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage at the decode/execute boundary.
// A 2-entry skid buffer (main + skid) keeps in_ready purely registered.
// Optional feature macro: IMM_EXT_BRANCH_EN enables sel 011 (sign-extend, shift left 2).
// When the macro is undefined, sel 011 is treated as illegal.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  imm_ext_pipe_if.slave     bus,
  output logic [CNT_W-1:0]  err_cnt
);

  logic             main_valid;
  logic [OUT_W-1:0] main_imm;
  logic             main_err;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_imm;
  logic             skid_err;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] new_imm;
  logic             new_err;
  logic             accept;
  logic             main_free;

  // Extend the incoming immediate according to the select code.
  always_comb begin
    sext    = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    new_imm = '0;
    new_err = 1'b0;
    case (bus.in_sel)
      3'b000: new_imm = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      3'b001: new_imm = sext;
      3'b010: new_imm = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
      3'b011: new_imm = sext << 2;
`endif
      default: begin
        new_imm = '0;
        new_err = 1'b1;
      end
    endcase
  end

  // Handshake qualifiers. An input offered during a flush is discarded.
  always_comb begin
    accept    = bus.in_valid && !skid_valid && !flush;
    main_free = !main_valid || bus.out_ready;
  end

  // Main/skid buffer. When main frees up, the skid (older) entry moves into main first,
  // so entries leave in the order they arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_err   <= skid_err;
        skid_valid <= accept;
        if (accept) begin
          skid_imm <= new_imm;
          skid_err <= new_err;
        end
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_imm <= new_imm;
          main_err <= new_err;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= new_imm;
      skid_err   <= new_err;
    end
  end

  // Saturating count of accepted illegal selects. It survives a flush and is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && new_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // Drive the outputs. in_ready comes only from the skid flop.
  always_comb begin
    bus.in_ready  = !skid_valid;
    bus.out_valid = main_valid;
    bus.out_imm   = main_imm;
    bus.out_err   = main_err;
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed self-checking bench for imm_ext_pipe.
// Expected values for sel 011 follow IMM_EXT_BRANCH_EN.
module tb_imm_ext_pipe;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int checks;
  int errors;
  int exp_cnt;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus2 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave), .err_cnt(err_cnt)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2.slave), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm got %h exp 0", bus.out_imm); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", bus.out_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    logic [2:0]  sels [4];
    logic [31:0] exps [4];
    logic        errs [4];
    sels = '{3'b000, 3'b001, 3'b010, 3'b011};
    exps[0] = 32'h0000_8001; errs[0] = 1'b0;
    exps[1] = 32'hFFFF_8001; errs[1] = 1'b0;
    exps[2] = 32'h8001_0000; errs[2] = 1'b0;
`ifdef IMM_EXT_BRANCH_EN
    exps[3] = 32'hFFFE_0004; errs[3] = 1'b0;
`else
    exps[3] = 32'h0000_0000; errs[3] = 1'b1;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_imm   = 16'h8001;
      bus.in_sel   = sels[i];
      if (errs[i]) exp_cnt++;
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got %b exp 1", i, bus.out_valid); end
      checks++; if (bus.out_imm !== exps[i]) begin errors++; $display("FAIL mode%0d_imm got %h exp %h", i, bus.out_imm, exps[i]); end
      checks++; if (bus.out_err !== errs[i]) begin errors++; $display("FAIL mode%0d_err got %b exp %b", i, bus.out_err, errs[i]); end
    end
    checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL modes_err_cnt got %0d exp %0d", err_cnt, exp_cnt); end
    idle(1);
  endtask

  task automatic test_branch_mode();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_imm    = 16'h0001;
    bus.in_sel    = 3'b011;
`ifdef IMM_EXT_BRANCH_EN
    tick();
    checks++; if (bus.out_imm !== 32'h0000_0004) begin errors++; $display("FAIL branch_imm got %h exp 00000004", bus.out_imm); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL branch_err got %b exp 0", bus.out_err); end
`else
    exp_cnt++;
    tick();
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL branch_imm got %h exp 00000000", bus.out_imm); end
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL branch_err got %b exp 1", bus.out_err); end
`endif
    checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL branch_err_cnt got %0d exp %0d", err_cnt, exp_cnt); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int idx;
    int n;
    idx = 0;
    n   = 0;
    bus.in_sel = 3'b001;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = (c >= 3);
      bus.in_valid  = (idx < 4);
      bus.in_imm    = 16'(idx + 1);
      #0;
      if (c == 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_c1 got %b exp 1", bus.in_ready); end
      end
      if (c == 2) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c2 got %b exp 0", bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_imm !== 32'(n + 1)) begin errors++; $display("FAIL bp_order got %h exp %h", bus.out_imm, 32'(n + 1)); end
        checks++; if (c !== 3 + n) begin errors++; $display("FAIL bp_gap got cycle %0d exp %0d", c, 3 + n); end
        n++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", n); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus.out_valid); end
    idle(1);
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_imm    = 16'h1234;
    bus.in_sel    = 3'b111;
    exp_cnt++;
    tick();
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL illegal_imm got %h exp 0", bus.out_imm); end
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", bus.out_err); end
    checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL illegal_err_cnt got %0d exp %0d", err_cnt, exp_cnt); end
    idle(1);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'b000;
    bus.in_imm    = 16'h0005;
    tick();
    bus.in_imm    = 16'h0006;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_imm !== 32'h5) begin errors++; $display("FAIL flush_pre_imm got %h exp 5", bus.out_imm); end
    bus.in_sel    = 3'b111;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", bus.in_ready); end
    checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL flush_err_cnt got %0d exp %0d", err_cnt, exp_cnt); end
    bus.in_sel = 3'b000;
    bus.in_imm = 16'h0007;
    tick();
    checks++; if (bus.out_imm !== 32'h7 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_after got %h/%b exp 7/1", bus.out_imm, bus.out_valid); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'b001;
    bus.in_imm    = 16'h8000;
    tick();
    bus.in_sel    = 3'b111;
    bus.in_imm    = 16'h0000;
    exp_cnt++;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_imm !== 32'hFFFF_8000 || bus.in_ready !== 1'b0 || err_cnt !== 8'(exp_cnt))
      begin errors++; $display("FAIL rstmid_pre got %h/%b/%0d exp ffff8000/0/%0d", bus.out_imm, bus.in_ready, err_cnt, exp_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL rstmid_imm got %h exp 0", bus.out_imm); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", bus.out_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_saturate();
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_sel    = 3'b111;
    bus2.in_imm    = 16'h00AA;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (err_cnt2 !== 2'((k < 3) ? k : 3)) begin errors++; $display("FAIL sat_k%0d got %0d exp %0d", k, err_cnt2, (k < 3) ? k : 3); end
    end
    bus2.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    flush2  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_imm    = '0;
    bus2.in_sel    = '0;
    bus2.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_branch_mode();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
